// File: rtl/imm_instr_encoder_pkg.sv
// imm_instr_encoder_pkg: format codes, RV32I opcodes and immediate range limits
package imm_instr_encoder_pkg;
   typedef enum logic [2:0] {
      RTYPE = 3'd0,
      ITYPE = 3'd1,
      STYPE = 3'd2,
      BTYPE = 3'd3,
      UTYPE = 3'd4,
      JTYPE = 3'd5
   } fmt_e;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -1048576;
   localparam int IMM21_MAX = 1048574;
endpackage

// File: rtl/imm_instr_encoder_imm_pack.sv
// imm_pack: range-checks the immediate and scatters fields into an RV32I word
module imm_pack
   import imm_instr_encoder_pkg::*;
(
   input  logic [2:0]  typ,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        ok
);
   logic signed [31:0] s;
   assign s = imm;
   always_comb begin
      ok = (typ == RTYPE) ? 1'b1
         : (typ == ITYPE || typ == STYPE) ? (s >= IMM12_MIN && s <= IMM12_MAX)
         : (typ == BTYPE) ? (s >= IMM13_MIN && s <= IMM13_MAX && !imm[0])
         : (typ == UTYPE) ? (imm[11:0] == 12'd0)
         : (typ == JTYPE) ? (s >= IMM21_MIN && s <= IMM21_MAX && !imm[0])
         : 1'b0;
      instr = (typ == RTYPE) ? {funct7, rs2, rs1, funct3, rd, opcode}
            : (typ == ITYPE) ? {imm[11:0], rs1, funct3, rd, opcode}
            : (typ == STYPE) ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
            : (typ == BTYPE) ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
            : (typ == UTYPE) ? {imm[31:12], rd, opcode}
            : (typ == JTYPE) ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
            : 32'd0;
   end
endmodule

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: two-stage valid/ready RV32I encoder with address counter and drop statistics
module imm_instr_encoder
   import imm_instr_encoder_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_type,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   output logic              err_sticky,
   output logic [7:0]        err_count
);
   logic              s1_valid, s1_ok, s2_free, s1_free, s1_adv;
   logic [2:0]        s1_type, s1_funct3;
   logic [6:0]        s1_opcode, s1_funct7;
   logic [4:0]        s1_rd, s1_rs1, s1_rs2;
   logic [31:0]       s1_imm, s1_instr;
   logic [ADDR_W-1:0] addr_cnt;
   assign s2_free  = !out_valid || out_ready;
   assign s1_free  = !s1_valid || s2_free;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = s1_free;
   imm_pack u_pack (
      .typ(s1_type), .opcode(s1_opcode), .funct3(s1_funct3), .funct7(s1_funct7),
      .rd(s1_rd), .rs1(s1_rs1), .rs2(s1_rs2), .imm(s1_imm),
      .instr(s1_instr), .ok(s1_ok)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_type    <= '0;
         s1_opcode  <= '0;
         s1_funct3  <= '0;
         s1_funct7  <= '0;
         s1_rd      <= '0;
         s1_rs1     <= '0;
         s1_rs2     <= '0;
         s1_imm     <= '0;
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_addr   <= '0;
         addr_cnt   <= BASE_ADDR;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         if (s1_free) begin
            s1_valid  <= in_valid;
            s1_type   <= in_type;
            s1_opcode <= in_opcode;
            s1_funct3 <= in_funct3;
            s1_funct7 <= in_funct7;
            s1_rd     <= in_rd;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_imm    <= in_imm;
         end
         if (s1_adv && s1_ok) begin
            out_valid <= 1'b1;
            out_instr <= s1_instr;
            out_addr  <= addr_cnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // a reload overrides the post-increment; the advancing word already latched the old value
         addr_cnt <= load_en ? load_addr : (s1_adv && s1_ok) ? addr_cnt + ADDR_W'(4) : addr_cnt;
         if (s1_adv && !s1_ok) begin
            err_sticky <= 1'b1;
            err_count  <= err_count + {7'd0, ~&err_count};
         end
      end
   end
endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb_imm_instr_encoder: directed and randomized checks against a field-level reference model
module tb_imm_instr_encoder;
   import imm_instr_encoder_pkg::*;
   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, load_en = 0;
   logic [2:0]  in_type = 0, in_funct3 = 0;
   logic [6:0]  in_opcode = 0, in_funct7 = 0;
   logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
   logic [31:0] in_imm = 0, load_addr = 0;
   logic        in_ready, out_valid, err_sticky;
   logic [31:0] out_instr, out_addr;
   logic [7:0]  err_count;
   typedef struct {logic [31:0] instr; logic [31:0] addr;} exp_t;
   exp_t        exp_q[$];
   int          checks = 0, errors = 0, m_err = 0;
   logic [31:0] m_addr = 0;
   bit          accepted;
   int          cur_t, cur_imm;
   bit [31:0]   cur_op, cur_f3, cur_f7, cur_rd, cur_rs1, cur_rs2;

   imm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .load_en(load_en), .load_addr(load_addr), .err_sticky(err_sticky), .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference encoder built from the field placement table with shifts and masks
   function automatic logic [31:0] ref_enc(int t, bit [31:0] op, f3, f7, rd, rs1, rs2, int imm, output bit ok);
      bit [31:0] u, base;
      u    = imm;
      base = op | (f3 << 12) | (rs1 << 15);
      ok   = 0;
      case (t)
         RTYPE: begin ok = 1; return base | (rd << 7) | (rs2 << 20) | (f7 << 25); end
         ITYPE: begin ok = imm >= -2048 && imm <= 2047; return base | (rd << 7) | ((u & 'hFFF) << 20); end
         STYPE: begin ok = imm >= -2048 && imm <= 2047; return base | ((u & 31) << 7) | (rs2 << 20) | (((u >> 5) & 'h7F) << 25); end
         BTYPE: begin
            ok = imm >= -4096 && imm <= 4094 && imm % 2 == 0;
            return base | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (rs2 << 20) | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
         end
         UTYPE: begin ok = (u & 'hFFF) == 0; return op | (rd << 7) | (u & 'hFFFFF000); end
         JTYPE: begin
            ok = imm >= -1048576 && imm <= 1048574 && imm % 2 == 0;
            return op | (rd << 7) | (((u >> 12) & 'hFF) << 12) | (((u >> 11) & 1) << 20) | (((u >> 1) & 'h3FF) << 21) | (((u >> 20) & 1) << 31);
         end
         default: return 0;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_in(int t, int op, int f3, int f7, int rd, int rs1, int rs2, int imm);
      cur_t = t; cur_op = op & 'h7F; cur_f3 = f3 & 7; cur_f7 = f7 & 'h7F;
      cur_rd = rd & 31; cur_rs1 = rs1 & 31; cur_rs2 = rs2 & 31; cur_imm = imm;
      in_type = 3'(t); in_opcode = 7'(op); in_funct3 = 3'(f3); in_funct7 = 7'(f7);
      in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
   endtask

   task automatic tick();
      bit acc, oh, ld, rs, ok;
      logic [31:0] w, la;
      exp_t e;
      @(negedge clk);
      rs = rst_n; acc = in_valid && in_ready; oh = out_valid && out_ready; ld = load_en; la = load_addr;
      w = ref_enc(cur_t, cur_op, cur_f3, cur_f7, cur_rd, cur_rs1, cur_rs2, cur_imm, ok);
      if (rs && oh) begin
         if (exp_q.size() == 0) chk("unexpected_output", out_instr, 32'hxxxxxxxx);
         else begin
            e = exp_q.pop_front();
            chk("sb_instr", out_instr, e.instr);
            chk("sb_addr", out_addr, e.addr);
         end
      end
      @(posedge clk);
      if (!rs) begin
         exp_q.delete(); m_addr = 0; m_err = 0;
      end else begin
         if (ld) m_addr = la;
         if (acc && ok) begin exp_q.push_back('{w, m_addr}); m_addr += 4; end
         else if (acc) m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      accepted = acc && rs;
      #1;
   endtask

   task automatic push();
      in_valid = 1;
      accepted = 0;
      for (int i = 0; i < 50 && !accepted; i++) begin
         tick();
         if (!accepted) out_ready = 1;
      end
      chk("accept_timeout", 32'(accepted), 1);
      in_valid = 0;
   endtask

   task automatic drain();
      out_ready = 1;
      in_valid = 0;
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) tick();
      chk("drain_left", 32'(exp_q.size()), 0);
   endtask

   task automatic reset();
      rst_n = 0; in_valid = 0; load_en = 0;
      tick(); tick();
      rst_n = 1;
   endtask

   task automatic rand_tuple();
      int t, imm;
      t = $urandom_range(0, 7);
      case (t)
         ITYPE, STYPE: imm = int'($urandom_range(0, 4200)) - 2100;
         BTYPE: begin imm = int'($urandom_range(0, 8400)) - 4200; if ($urandom_range(0, 3) != 0) imm &= ~1; end
         JTYPE: begin imm = int'($urandom_range(0, 2200000)) - 1100000; if ($urandom_range(0, 3) != 0) imm &= ~1; end
         UTYPE: begin imm = $urandom; if ($urandom_range(0, 3) != 0) imm &= ~'hFFF; end
         default: imm = $urandom;
      endcase
      set_in(t, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
   endtask

   int          st_t[4]   = '{STYPE, BTYPE, JTYPE, UTYPE};
   int          st_op[4]  = '{'h23, 'h63, 'h6F, 'h37};
   int          st_rd[4]  = '{0, 0, 1, 5};
   int          st_rs1[4] = '{1, 0, 0, 0};
   int          st_rs2[4] = '{2, 0, 0, 0};
   int          st_f3[4]  = '{2, 0, 0, 0};
   int          st_imm[4] = '{8, -4, 2048, 'h12345000};
   logic [31:0] st_w[4]   = '{32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
   int          bt[15] = '{ITYPE, ITYPE, ITYPE, ITYPE, STYPE, BTYPE, BTYPE, BTYPE, BTYPE, JTYPE, JTYPE, JTYPE, UTYPE, UTYPE, 7};
   int          bi[15] = '{2047, -2048, -2049, 2048, -2048, 4094, -4096, 4096, -4098, 1048574, -1048576, 1048576, 'hFFFFF000, 'h800, 0};
   int          n_acc;

   initial begin
      reset();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_err_count", 32'(err_count), 0);
      chk("rst_err_sticky", 32'(err_sticky), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 5);
      push();
      chk("lat_not_yet", 32'(out_valid), 0);
      tick();
      chk("lat_valid", 32'(out_valid), 1);
      chk("lat_instr", out_instr, 32'h00500093);
      chk("lat_addr", out_addr, 0);
      drain();
      reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            set_in(st_t[k], st_op[k], st_f3[k], 0, st_rd[k], st_rs1[k], st_rs2[k], st_imm[k]);
            push();
         end else tick();
         if (k > 0) begin
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_instr", out_instr, st_w[k-1]);
            chk("stream_addr", out_addr, 32'(4 * (k - 1)));
         end
      end
      drain();
      reset();
      set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 2048);
      push(); drain();
      chk("range_i_count", 32'(err_count), 1);
      chk("range_i_sticky", 32'(err_sticky), 1);
      set_in(BTYPE, 'h63, 0, 0, 0, 1, 2, 3);
      push(); drain();
      chk("range_b_count", 32'(err_count), 2);
      set_in(ITYPE, 'h13, 0, 0, 2, 0, 0, 7);
      push(); tick();
      chk("range_next_addr", out_addr, 0);
      drain();
      for (int i = 0; i < 300; i++) begin
         set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 2048 + int'($urandom_range(0, 1000)));
         push();
      end
      drain();
      chk("sat_count", 32'(err_count), 255);
      chk("sat_sticky", 32'(err_sticky), 1);
      reset();
      for (int i = 0; i < 15; i++) begin
         set_in(bt[i], $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127), 3, 4, 5, bi[i]);
         push();
      end
      drain();
      chk("bnd_err_count", 32'(err_count), 32'(m_err));
      reset();
      out_ready = 0;
      n_acc = 0;
      for (int c = 0; c < 5; c++) begin
         set_in(ITYPE, 'h13, 0, 0, n_acc + 1, 0, 0, 100 + n_acc);
         in_valid = 1;
         tick();
         if (accepted) n_acc++;
         if (c >= 2) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_stable_instr", out_instr, 32'h06400093);
            chk("bp_stable_addr", out_addr, 0);
         end
      end
      chk("bp_accepted", 32'(n_acc), 2);
      out_ready = 1;
      push();
      drain();
      load_en = 1; load_addr = 32'hFFFFFFFC;
      tick();
      load_en = 0;
      set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 1); push();
      set_in(ITYPE, 'h13, 0, 0, 2, 0, 0, 2); push();
      chk("load_first", out_addr, 32'hFFFFFFFC);
      tick();
      chk("load_wrap", out_addr, 0);
      set_in(OP_IMM == 7'h13 ? RTYPE : ITYPE, 'h33, 0, 0, 3, 1, 2, 0); push();
      load_en = 1; load_addr = 32'h100;
      tick();
      load_en = 0;
      chk("coinc_old_addr", out_addr, 4);
      set_in(ITYPE, 'h13, 0, 0, 4, 0, 0, 4); push();
      tick();
      chk("coinc_new_addr", out_addr, 32'h100);
      drain();
      reset();
      for (int i = 0; i < 200; i++) begin
         rand_tuple();
         out_ready = ($urandom_range(0, 3) != 0);
         push();
         if ($urandom_range(0, 4) == 0) tick();
      end
      drain();
      chk("rand_err_count", 32'(err_count), 32'(m_err));
      set_in(UTYPE, 'h37, 0, 0, 1, 0, 0, 1);
      push(); drain();
      chk("mid_pre_sticky", 32'(err_sticky), 1);
      out_ready = 0;
      set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 9); push();
      set_in(ITYPE, 'h13, 0, 0, 2, 0, 0, 10); push();
      chk("mid_full_in_ready", 32'(in_ready), 0);
      rst_n = 0; out_ready = 1;
      tick();
      rst_n = 1;
      chk("mid_out_valid", 32'(out_valid), 0);
      chk("mid_err_count", 32'(err_count), 0);
      chk("mid_err_sticky", 32'(err_sticky), 0);
      set_in(ITYPE, 'h13, 0, 0, 1, 0, 0, 11); push();
      tick();
      chk("mid_base_addr", out_addr, 0);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_instr_encoder.md
# imm_instr_encoder

Streaming RISC-V RV32I instruction encoder, the inverse of the CPU's immediate-extraction path. It accepts decoded instruction fields, range-checks the immediate and scatters it into the R/I/S/B/U/J bit layouts. Each valid 32-bit instruction word is emitted with an auto-incrementing byte address. It sits in the test/boot infrastructure, upstream of instruction-memory initialisation, behind a two-stage valid/ready pipeline.

## Interface
- ADDR_W, 32: width of out_addr.
- BASE_ADDR, 0: address counter value after reset.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder accepts the tuple this cycle.
- in_type  in  3  format: RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE shared constants.
- in_opcode  in  7; in_funct3  in  3; in_funct7  in  7  opcode and function fields.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address assigned to out_instr.
- load_en  in  1  reload address counter.
- load_addr  in  ADDR_W  new counter value.
- err_sticky  out  1  set on any dropped tuple; cleared only by reset.
- err_count  out  8  dropped-tuple count, saturates at 255.

## Operation
- Stage 1 (S1) registers the tuple and computes `ok`.
- Stage 2 (S2) is the output register. It holds out_instr, out_addr and out_valid.
- Range rules:
  - I, S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094], imm[0]=0.
  - J: imm in [-2^20, 2^20-2], imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, always ok.
  - Any other in_type value: not ok.
- Packing (opcode in [6:0] for all formats):
  - R: {funct7, rs2, rs1, funct3, rd}.
  - I: {imm[11:0], rs1, funct3, rd}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]}.
  - U: {imm[31:12], rd}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
  - Unused fields are ignored.
- Handshakes:
  - s2_free = !out_valid | out_ready.
  - s1_free = !s1_valid | s2_free.
  - in_ready = s1_free, combinational from out_ready.
- When S1 advances and is ok:
  - S2 loads the instruction with out_addr = addr_cnt.
  - addr_cnt += 4, wrapping modulo 2^ADDR_W.
- When S1 advances and is not ok:
  - The tuple is dropped and S2 does not load.
  - err_sticky is set and err_count increments (saturating at 255).
  - addr_cnt is unchanged.
- When S2 is not refilled and out_ready=1, out_valid clears.
- load_en: addr_cnt <= load_addr at the clock edge.
  - If an ok S1 advances in the same cycle, that instruction still takes the old addr_cnt.
  - The next instruction takes load_addr; the load wins over the +4.

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=0, s1_valid=0, addr_cnt=BASE_ADDR, err_sticky=0, err_count=0.
- in_ready is 1 in the first cycle after reset.
- Latency: a tuple accepted at edge N appears with out_valid=1 after edge N+1 (2-cycle pipeline).
- Throughput: one instruction per cycle with out_ready held high.
- Stall with out_ready=0:
  - Both stages fill; in_ready falls once S1 is occupied behind full S2.
  - out_instr/out_addr are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream discards both stages and any in-flight tuple. No output handshake completes on that edge.
- Simultaneous S2 drain and S1 advance is a same-cycle replace: no bubble.

## Structure
- The shared parameters package holds:
  - format constants RTYPE..JTYPE (same values the CPU decode path uses);
  - RV32I opcode constants;
  - range limits.
- Sub-module imm_pack: combinational {type, fields, imm} -> {instr, ok}, instantiated once in S1.
- The top level holds the pipeline registers, address counter and error counter.

## Test plan
- ITYPE, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 after reset -> out_instr=0x00500093, out_addr=0x0, two cycles after acceptance.
- Back-to-back stream with out_ready=1:
  - STYPE 0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423 at addr 0x0.
  - BTYPE 0x63, imm=-4 -> 0xFE000EE3 at addr 0x4.
  - JTYPE 0x6F, rd=1, imm=2048 -> 0x001000EF at addr 0x8.
  - UTYPE 0x37, rd=5, imm=0x12345000 -> 0x123452B7 at addr 0xC.
  - No bubbles between outputs.
- Range errors:
  - ITYPE imm=2048 -> dropped, err_count=1, err_sticky=1.
  - BTYPE imm=3 -> dropped, err_count=2.
  - Next valid instruction gets the unadvanced address.
  - 300 bad tuples -> err_count=255.
- Backpressure:
  - out_ready=0 for 5 cycles with 3 tuples offered -> exactly 2 accepted, in_ready=0, outputs stable.
  - Release -> all 3 emitted in order with addresses +4 apart.
- load_en with load_addr=0xFFFFFFFC, then 2 instructions -> addrs 0xFFFFFFFC, 0x00000000.
- load_en coinciding with an S1 advance -> that instruction keeps the old address.
- rst_n=0 for one cycle with both stages full -> out_valid=0 next cycle, addr_cnt=BASE_ADDR, err_count=0.
